// File: rtl/microwave_ctrl.sv
// rtl/microwave_ctrl.sv - microwave sequencing FSM driving Timer, magnetron and beep
// Optional quick-start (0:30 on start with empty timer) enabled by defining QUICK_START_EN.
module microwave_ctrl #(
    parameter int MAX_DIGITS  = 3,
    parameter int BEEP_CYCLES = 3,
    parameter int DIGIT_W     = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_data,
    input  logic               start,
    input  logic               stop,
    input  logic               door_closed,
    input  logic               timer_zero,
    output logic               timer_load_n,
    output logic               timer_clr_n,
    output logic               timer_en_n,
    output logic [DIGIT_W-1:0] timer_data,
    output logic               mag_on,
    output logic               beep,
    output logic [2:0]         state
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        COOK   = 3'd2,
        PAUSED = 3'd3,
`ifdef QUICK_START_EN
        QLOAD1 = 3'd5,
        QLOAD2 = 3'd6,
`endif
        DONE   = 3'd4
    } state_t;

    state_t             state_r, state_n;
    logic [CW-1:0]      digit_cnt, cnt_n;
    logic [BW-1:0]      beep_cnt, bcnt_n;
    logic               load_n_n, clr_n_n;
    logic [DIGIT_W-1:0] data_n;
    logic               key_ok, start_ok;

    assign key_ok   = key_valid && (key_data <= DIGIT_W'(9));
    assign start_ok = start && door_closed && !timer_zero;
    assign state    = state_r;

    always_comb begin
        state_n  = state_r;
        cnt_n    = digit_cnt;
        bcnt_n   = beep_cnt;
        load_n_n = 1'b1;
        clr_n_n  = 1'b1;
        data_n   = timer_data;
        case (state_r)
            IDLE: begin
                if (stop) begin
                    clr_n_n = 1'b0;
                end else if (start_ok) begin
                    state_n = COOK;
`ifdef QUICK_START_EN
                end else if (start && door_closed && timer_zero) begin
                    state_n  = QLOAD1;
                    load_n_n = 1'b0;
                    data_n   = DIGIT_W'(3);
`endif
                end else if (key_ok) begin
                    state_n  = ENTRY;
                    load_n_n = 1'b0;
                    data_n   = key_data;
                    cnt_n    = CW'(1);
                end
            end
            ENTRY: begin
                if (stop) begin
                    state_n = IDLE;
                    clr_n_n = 1'b0;
                    cnt_n   = '0;
                end else if (start_ok) begin
                    state_n = COOK;
                    cnt_n   = '0;
                end else if (key_ok && digit_cnt < CW'(MAX_DIGITS)) begin
                    load_n_n = 1'b0;
                    data_n   = key_data;
                    cnt_n    = digit_cnt + CW'(1);
                end
            end
            COOK: begin
                if (timer_zero) begin
                    state_n = DONE;
                    bcnt_n  = BW'(1);
                end else if (stop || !door_closed) begin
                    state_n = PAUSED;
                end
            end
            PAUSED: begin
                if (stop) begin
                    state_n = IDLE;
                    clr_n_n = 1'b0;
                end else if (start_ok) begin
                    state_n = COOK;
                end
            end
            DONE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (key_ok) begin
                    state_n  = ENTRY;
                    load_n_n = 1'b0;
                    data_n   = key_data;
                    cnt_n    = CW'(1);
                end else if (beep_cnt < BW'(BEEP_CYCLES)) begin
                    bcnt_n = beep_cnt + BW'(1);
                end else begin
                    state_n = IDLE;
                end
            end
`ifdef QUICK_START_EN
            QLOAD1: begin
                if (stop) begin
                    state_n = IDLE;
                    clr_n_n = 1'b0;
                end else begin
                    state_n  = QLOAD2;
                    load_n_n = 1'b0;
                    data_n   = '0;
                end
            end
            QLOAD2: begin
                if (stop) begin
                    state_n = IDLE;
                    clr_n_n = 1'b0;
                end else begin
                    state_n = COOK;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they change with the state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r      <= IDLE;
            digit_cnt    <= '0;
            beep_cnt     <= '0;
            timer_clr_n  <= 1'b0;
            timer_load_n <= 1'b1;
            timer_en_n   <= 1'b1;
            timer_data   <= '0;
            mag_on       <= 1'b0;
            beep         <= 1'b0;
        end else begin
            state_r      <= state_n;
            digit_cnt    <= cnt_n;
            beep_cnt     <= bcnt_n;
            timer_clr_n  <= clr_n_n;
            timer_load_n <= load_n_n;
            timer_en_n   <= (state_n != COOK);
            timer_data   <= data_n;
            mag_on       <= (state_n == COOK);
            beep         <= (state_n == DONE);
        end
    end

endmodule
